// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction handling, timed stepping, segment storage,
// growth, wall/self/stone death detection and a registered cell-occupancy query.
//
// state | meaning
// IDLE  | waiting for game_start, body/len/dir frozen at the start layout
// PLAY  | tick counter running, snake steps on each tick wrap
// DIE   | collision seen, everything frozen until game_start reloads the body
module snake_body_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 12500000,
  parameter int INIT_X   = 10,
  parameter int INIT_Y   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       game_start,
  input  logic       add_cube,
  input  logic       hit_stone,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] snake_len,
  output logic [1:0] game_status,
  output logic       step,
  input  logic [5:0] qry_x,
  input  logic [4:0] qry_y,
  output logic       cell_body,
  output logic       cell_head
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_DIE = 2'd2} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t         state, state_nxt;
  dir_t           dir, pend, pend_nxt, req;
  logic           req_vld;
  logic [5:0]     seg_x [MAX_LEN];
  logic [5:0]     seg_y [MAX_LEN];
  logic [4:0]     len;
  logic           grow_pending;
  logic [TW-1:0]  tick_cnt;
  logic           tick_wrap, step_try, wall_hit, self_hit, do_move, grows;
  logic [5:0]     nx, ny;
  logic           body_hit, head_hit;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  // Key priority and reversal filter; a key on the step cycle feeds that step.
  always_comb begin
    req     = DIR_RIGHT;
    req_vld = key_up | key_down | key_left | key_right;
    if (key_up)        req = DIR_UP;
    else if (key_down) req = DIR_DOWN;
    else if (key_left) req = DIR_LEFT;
    pend_nxt = (req_vld && (req != opposite(dir))) ? req : pend;
  end

  // Next head position and collision checks; the tail cell only blocks when it stays.
  always_comb begin
    nx = seg_x[0];
    ny = seg_y[0];
    case (pend_nxt)
      DIR_UP:   ny = seg_y[0] - 6'd1;
      DIR_DOWN: ny = seg_y[0] + 6'd1;
      DIR_LEFT: nx = seg_x[0] - 6'd1;
      default:  nx = seg_x[0] + 6'd1;
    endcase
    wall_hit = (nx == 6'd0) || (nx == 6'(GRID_W - 1)) ||
               (ny == 6'd0) || (ny == 6'(GRID_H - 1));
    grows    = (grow_pending | add_cube) && (len < 5'(MAX_LEN));
    self_hit = 1'b0;
    for (int j = 1; j < MAX_LEN; j++) begin
      if ((j + 2 <= int'(len)) || (grows && (j + 1 == int'(len)))) begin
        if ((seg_x[j] == nx) && (seg_y[j] == ny)) self_hit = 1'b1;
      end
    end
    tick_wrap = (state == ST_PLAY) && (tick_cnt == TICK_LAST);
    step_try  = tick_wrap && !hit_stone;
    do_move   = step_try && !wall_hit && !self_hit;
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Game state transitions; a stone kills immediately, ahead of any step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (game_start) state_nxt = ST_PLAY;
      ST_PLAY: if (hit_stone || (step_try && (wall_hit || self_hit))) state_nxt = ST_DIE;
      ST_DIE:  if (game_start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Body, length, direction, growth flag and tick counter.
  always_ff @(posedge clk) begin
    if (rst || ((state == ST_DIE) && game_start)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
        seg_y[i] <= (i < INIT_LEN) ? 6'(INIT_Y) : 6'd0;
      end
      len          <= 5'(INIT_LEN);
      dir          <= DIR_RIGHT;
      pend         <= DIR_RIGHT;
      grow_pending <= 1'b0;
      tick_cnt     <= '0;
      step         <= 1'b0;
    end else begin
      step <= do_move;
      if ((state != ST_PLAY) || tick_wrap) tick_cnt <= '0;
      else                                 tick_cnt <= tick_cnt + TW'(1);
      if (state == ST_PLAY) begin
        pend <= pend_nxt;
        if (add_cube) grow_pending <= 1'b1;
      end
      if (do_move) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          if ((i < int'(len)) || (grows && (i == int'(len)))) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
        end
        seg_x[0]     <= nx;
        seg_y[0]     <= ny;
        dir          <= pend_nxt;
        grow_pending <= 1'b0;
        if (grows) len <= len + 5'd1;
      end
    end
  end

  // Occupancy of the queried cell over the active segments.
  always_comb begin
    body_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && (seg_x[i] == qry_x) && (seg_y[i] == {1'b0, qry_y}))
        body_hit = 1'b1;
    end
    head_hit = (seg_x[0] == qry_x) && (seg_y[0] == {1'b0, qry_y});
  end

  // Registered query results for the renderer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_body <= 1'b0;
      cell_head <= 1'b0;
    end else begin
      cell_body <= body_hit;
      cell_head <= head_hit;
    end
  end

  assign head_x      = seg_x[0];
  assign head_y      = seg_y[0];
  assign snake_len   = len;
  assign game_status = state;

endmodule
